// File: rtl/fb_pkg.sv
// Shared register offsets, FSM states and buffer-role arithmetic for the
// multi-buffer framebuffer controller.
package fb_pkg;

    localparam logic [7:0] REG_SWAP = 8'hFC;
    localparam logic [7:0] REG_CCOL = 8'hF8;
    localparam logic [7:0] REG_STAT = 8'hF4;
    localparam logic [7:0] REG_CTRL = 8'hF0;

    typedef enum logic [1:0] {INIT, IDLE, CLEAR} fb_state_t;

    // Buffer index that sits 'off' places after base index b in the ring.
    function automatic logic [2:0] role_idx(input logic [2:0] b, input logic [2:0] off,
                                            input int nbuf);
        int s;
        s = int'(b) + int'(off);
        return 3'(s % nbuf);
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One framebuffer: simple dual-port RAM with one write port and one
// registered read port, both on clk.
module fb_bank #(
    parameter int AW = 20,
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/fb_multibuf_ctrl.sv
// N-buffer framebuffer controller: MMIO draw access, vblank-synchronous buffer
// rotation, hardware clear engine and pixel-rate scanout.
module fb_multibuf_ctrl
    import fb_pkg::*;
#(
    parameter int BPP   = 1,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int NBUF  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [23:0]    bus_addr,
    input  logic [31:0]    bus_wdata,
    input  logic           bus_we,
    input  logic           bus_re,
    output logic [31:0]    bus_rdata,
    output logic           bus_rvalid,
    input  logic           pix_en,
    input  logic [X_W-1:0] pix_x,
    input  logic [Y_W-1:0] pix_y,
    input  logic           vblank,
    output logic [BPP-1:0] pix_data,
    output logic           pix_valid,
    output logic           swap_pending,
    output logic           clear_busy,
    output logic           irq_swap
);

    localparam int AW = X_W + Y_W;

    fb_state_t      state_q;
    logic [X_W-1:0] sx_q;
    logic [Y_W-1:0] sy_q;
    logic [2:0]     b_q;
    logic           pend_q, auto_clear_q, vb_q, vb_prev_q, irq_q;
    logic [BPP-1:0] ccol_q, ccol_lat_q;
    logic           pv_q, pok_q, rv_q, rsel_pix_q;
    logic [2:0]     pdisp_q, rdraw_q;
    logic [31:0]    rreg_q, reg_rd_d;

    logic [2:0]     disp_idx, draw_idx, retire_idx;
    logic           pix_sel, reg_sel, reg_we, bus_in_range, pix_in_range;
    logic           sweep_last, commit;
    logic [AW-1:0]  sweep_addr, pix_addr;
    logic [BPP-1:0] bank_rdata [0:7];
    logic           unused_ok;

    assign disp_idx   = b_q;
    assign draw_idx   = role_idx(b_q, 3'd1, NBUF);
    assign retire_idx = role_idx(b_q, 3'(NBUF - 1), NBUF);

    assign pix_sel      = (bus_addr[23:20] == 4'd0);
    assign reg_sel      = (bus_addr[23:8] == 16'hFFFF);
    assign reg_we       = bus_we && reg_sel;
    assign bus_in_range = pix_sel && (int'(bus_addr[X_W-1:0]) < H_RES)
                                  && (int'(bus_addr[AW-1:X_W]) < V_RES);
    assign pix_in_range = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
    assign pix_addr     = {pix_y, pix_x};
    assign sweep_addr   = {sy_q, sx_q};
    assign sweep_last   = (int'(sx_q) == H_RES - 1) && (int'(sy_q) == V_RES - 1);
    assign commit       = vb_q && !vb_prev_q && pend_q && (state_q == IDLE);
    assign unused_ok    = ^{bus_wdata[31:BPP], bus_addr[19:AW]};

    // The display buffer's read port always belongs to scanout; every other
    // bank's port serves bus reads. Clear/INIT writes take priority over the bus.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bank
            if (gi < NBUF) begin : g_used
                logic           we;
                logic [AW-1:0]  wa, ra;
                logic [BPP-1:0] wd;
                always_comb begin
                    we = 1'b0;
                    wa = bus_addr[AW-1:0];
                    wd = bus_wdata[BPP-1:0];
                    if (state_q == INIT) begin
                        we = 1'b1;
                        wa = sweep_addr;
                        wd = '0;
                    end else if (state_q == CLEAR && retire_idx == 3'(gi)) begin
                        we = 1'b1;
                        wa = sweep_addr;
                        wd = ccol_lat_q;
                    end else if (bus_we && bus_in_range && draw_idx == 3'(gi)) begin
                        we = 1'b1;
                    end
                    ra = (disp_idx == 3'(gi)) ? pix_addr : bus_addr[AW-1:0];
                end
                fb_bank #(.AW(AW), .DW(BPP)) u_bank (
                    .clk     (clk),
                    .we_i    (we),
                    .waddr_i (wa),
                    .wdata_i (wd),
                    .raddr_i (ra),
                    .rdata_o (bank_rdata[gi])
                );
            end else begin : g_unused
                assign bank_rdata[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        reg_rd_d = '0;
        case (bus_addr[7:0])
            REG_CCOL: reg_rd_d = {{(32-BPP){1'b0}}, ccol_q};
            REG_STAT: reg_rd_d = {24'b0, clear_busy, pend_q, 3'b0, b_q};
            REG_CTRL: reg_rd_d = {31'b0, auto_clear_q};
            default:  reg_rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= INIT;
            sx_q         <= '0;
            sy_q         <= '0;
            b_q          <= '0;
            pend_q       <= 1'b0;
            auto_clear_q <= 1'b1;
            ccol_q       <= '0;
            ccol_lat_q   <= '0;
            vb_q         <= 1'b0;
            vb_prev_q    <= 1'b0;
            irq_q        <= 1'b0;
            pv_q         <= 1'b0;
            pok_q        <= 1'b0;
            pdisp_q      <= '0;
            rv_q         <= 1'b0;
            rsel_pix_q   <= 1'b0;
            rdraw_q      <= '0;
            rreg_q       <= '0;
        end else begin
            vb_q      <= vblank;
            vb_prev_q <= vb_q;
            irq_q     <= commit;
            if (commit) b_q <= draw_idx;
            // A request arriving in the commit cycle becomes the next pending swap.
            if (reg_we && bus_addr[7:0] == REG_SWAP) pend_q <= 1'b1;
            else if (commit)                         pend_q <= 1'b0;
            if (reg_we && bus_addr[7:0] == REG_CCOL) ccol_q <= bus_wdata[BPP-1:0];
            if (reg_we && bus_addr[7:0] == REG_CTRL) auto_clear_q <= bus_wdata[0];

            case (state_q)
                INIT, CLEAR: begin
                    if (sweep_last) begin
                        state_q <= IDLE;
                        sx_q    <= '0;
                        sy_q    <= '0;
                    end else if (int'(sx_q) == H_RES - 1) begin
                        sx_q <= '0;
                        sy_q <= sy_q + Y_W'(1);
                    end else begin
                        sx_q <= sx_q + X_W'(1);
                    end
                end
                IDLE: begin
                    if (commit && auto_clear_q) begin
                        state_q    <= CLEAR;
                        ccol_lat_q <= ccol_q;
                    end
                end
                default: state_q <= INIT;
            endcase

            pv_q       <= pix_en;
            pok_q      <= pix_en && pix_in_range && (state_q != INIT);
            pdisp_q    <= disp_idx;
            rv_q       <= bus_re;
            rsel_pix_q <= bus_re && bus_in_range;
            rdraw_q    <= draw_idx;
            rreg_q     <= (bus_re && reg_sel) ? reg_rd_d : '0;
        end
    end

    assign pix_valid    = pv_q;
    assign pix_data     = pok_q ? bank_rdata[pdisp_q] : '0;
    assign bus_rvalid   = rv_q;
    assign bus_rdata    = rsel_pix_q ? {{(32-BPP){1'b0}}, bank_rdata[rdraw_q]} : rreg_q;
    assign swap_pending = pend_q;
    assign clear_busy   = (state_q != IDLE);
    assign irq_swap     = irq_q;

endmodule

// File: tb/tb_fb_multibuf_ctrl.sv
// Directed bench for fb_multibuf_ctrl on a small 12x6, 4-bpp, 3-buffer configuration.
module tb_fb_multibuf_ctrl;

    localparam int AREA = 12 * 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_we = 1'b0, bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic        pix_en = 1'b0;
    logic [3:0]  pix_x = '0;
    logic [2:0]  pix_y = '0;
    logic        vblank = 1'b0;
    logic [3:0]  pix_data;
    logic        pix_valid, swap_pending, clear_busy, irq_swap;

    int total = 0;
    int bad = 0;
    int irq_cnt = 0;
    int busy_cnt = 0;

    fb_multibuf_ctrl #(.BPP(4), .H_RES(12), .V_RES(6), .X_W(4), .Y_W(3), .NBUF(3)) dut (
        .clk(clk), .reset(reset),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y), .vblank(vblank),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .swap_pending(swap_pending), .clear_busy(clear_busy), .irq_swap(irq_swap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq_swap)   irq_cnt  <= irq_cnt + 1;
        if (clear_busy) busy_cnt <= busy_cnt + 1;
    end

    typedef enum int {OP_PW, OP_PR, OP_RW, OP_RR, OP_PF} op_t;
    typedef struct {
        op_t         op;
        logic [23:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [23:0] pa(input int x, input int y);
        return 24'(y * 16 + x);
    endfunction

    function automatic logic [23:0] ra(input logic [7:0] off);
        return {16'hFFFF, off};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        tick();
        bus_we = 1'b0;
        $display("wr  addr=%h data=%h", a, d);
    endtask

    task automatic bus_read(input logic [23:0] a, input logic [31:0] exp, input string name);
        bus_addr = a; bus_re = 1'b1;
        tick();
        bus_re = 1'b0;
        $display("rd  addr=%h data=%h valid=%b", a, bus_rdata, bus_rvalid);
        check({name, "_valid"}, 32'(bus_rvalid), 32'd1);
        check(name, bus_rdata, exp);
    endtask

    task automatic fetch(input int x, input int y, input logic [31:0] exp, input string name);
        pix_x = 4'(x); pix_y = 3'(y); pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        $display("pix (%0d,%0d) data=%h valid=%b", x, y, pix_data, pix_valid);
        check({name, "_valid"}, 32'(pix_valid), 32'd1);
        check(name, 32'(pix_data), exp);
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        repeat (4) tick();
        vblank = 1'b0;
        repeat (2) tick();
        $display("vblank pulse irq_cnt=%0d", irq_cnt);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (clear_busy && n < 500) begin
            tick();
            n++;
        end
        check("wait_idle_bound", 32'(clear_busy), 32'd0);
    endtask

    initial begin
        int n, irq0, busy0;

        vecs.push_back('{OP_PR, pa(10, 5), 32'h0, 32'h0, "rd_blank"});
        vecs.push_back('{OP_PW, pa(10, 5), 32'h7, 32'h0, "wr_10_5"});
        vecs.push_back('{OP_PR, pa(10, 5), 32'h0, 32'h7, "rd_10_5"});
        vecs.push_back('{OP_PR, pa(11, 5), 32'h0, 32'h0, "rd_11_5"});
        vecs.push_back('{OP_PW, pa(12, 0), 32'h5, 32'h0, "wr_x_oob"});
        vecs.push_back('{OP_PR, pa(12, 0), 32'h0, 32'h0, "rd_x_oob"});
        vecs.push_back('{OP_PW, pa(0, 6),  32'h9, 32'h0, "wr_y_oob"});
        vecs.push_back('{OP_PR, pa(0, 6),  32'h0, 32'h0, "rd_y_oob"});
        vecs.push_back('{OP_PW, pa(0, 0),  32'hA, 32'h0, "wr_0_0"});
        vecs.push_back('{OP_PR, pa(0, 0),  32'h0, 32'hA, "rd_0_0"});
        vecs.push_back('{OP_PW, pa(1, 1),  32'hFFFF_FFF5, 32'h0, "wr_wide"});
        vecs.push_back('{OP_PR, pa(1, 1),  32'h0, 32'h5, "rd_wide"});
        vecs.push_back('{OP_RR, ra(8'hF0), 32'h0, 32'h1, "ctrl_rst"});
        vecs.push_back('{OP_RR, ra(8'hF8), 32'h0, 32'h0, "ccol_rst"});
        vecs.push_back('{OP_RW, ra(8'hF8), 32'h3, 32'h0, "ccol_wr"});
        vecs.push_back('{OP_RR, ra(8'hF8), 32'h0, 32'h3, "ccol_rd"});
        vecs.push_back('{OP_RR, ra(8'hF4), 32'h0, 32'h0, "stat_idle"});
        vecs.push_back('{OP_RR, ra(8'hE0), 32'h0, 32'h0, "reg_other"});
        vecs.push_back('{OP_PF, pa(10, 5), 32'h0, 32'h0, "pix_disp_10_5"});
        vecs.push_back('{OP_PF, pa(0, 0),  32'h0, 32'h0, "pix_disp_0_0"});
        vecs.push_back('{OP_RW, ra(8'hFC), 32'h1, 32'h0, "swap_req"});
        vecs.push_back('{OP_RR, ra(8'hF4), 32'h0, 32'h40, "stat_pend"});
        vecs.push_back('{OP_RW, ra(8'hFC), 32'h1, 32'h0, "swap_req2"});
        vecs.push_back('{OP_RR, ra(8'hF4), 32'h0, 32'h40, "stat_pend2"});

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(clear_busy), 32'd1);
        check("rst_pend", 32'(swap_pending), 32'd0);
        check("rst_irq", 32'(irq_swap), 32'd0);
        check("rst_rvalid", 32'(bus_rvalid), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_pvalid", 32'(pix_valid), 32'd0);
        check("rst_pdata", 32'(pix_data), 32'd0);
        reset = 1'b0;

        // INIT sweep: first cycle spent on a scanout fetch that must read 0
        fetch(5, 5, 32'h0, "pix_init");
        wait_idle(n);
        check("init_cycles", 32'(n + 1), 32'(AREA));
        fetch(5, 5, 32'h0, "pix_after_init");

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_PW, OP_RW: bus_write(vecs[i].addr, vecs[i].data);
                OP_PR, OP_RR: bus_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
                default: fetch(int'(vecs[i].addr[3:0]), int'(vecs[i].addr[6:4]),
                               vecs[i].exp, vecs[i].name);
            endcase
        end

        // First commit: one rotation despite two requests; CLEAR of bank 0 with colour 3
        irq0 = irq_cnt; busy0 = busy_cnt;
        vblank_pulse();
        check("irq_commit1", 32'(irq_cnt - irq0), 32'd1);
        bus_read(ra(8'hF4), 32'h81, "stat_commit1");
        fetch(10, 5, 32'h7, "pix_new_disp");

        // Swap blocked while the clear engine runs; mid-clear colour change
        bus_write(ra(8'hFC), 32'h1);
        bus_write(ra(8'hF8), 32'h6);
        irq0 = irq_cnt;
        vblank_pulse();
        check("irq_blocked", 32'(irq_cnt - irq0), 32'd0);
        bus_read(ra(8'hF4), 32'hC1, "stat_blocked");
        wait_idle(n);
        check("clear_cycles", 32'(busy_cnt - busy0), 32'(AREA));
        bus_read(ra(8'hF4), 32'h41, "stat_after_clear");

        // Deferred commit: bank 0 becomes draw, holding the latched colour 3
        irq0 = irq_cnt;
        vblank_pulse();
        check("irq_commit2", 32'(irq_cnt - irq0), 32'd1);
        bus_read(pa(3, 2), 32'h3, "rd_cleared_3_2");
        bus_read(pa(10, 5), 32'h3, "rd_cleared_10_5");
        wait_idle(n);

        // Wrap back to b=0: bank 1 was cleared with colour 6
        bus_write(ra(8'hFC), 32'h1);
        irq0 = irq_cnt;
        vblank_pulse();
        check("irq_commit3", 32'(irq_cnt - irq0), 32'd1);
        bus_read(ra(8'hF4), 32'h80, "stat_wrap");
        fetch(3, 2, 32'h3, "pix_wrap_3_2");
        bus_read(pa(10, 5), 32'h6, "rd_clear6");

        // Reset in the middle of CLEAR with a pending swap
        repeat (25) tick();
        bus_write(ra(8'hFC), 32'h1);
        check("pend_before_rst", 32'(swap_pending), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_pend", 32'(swap_pending), 32'd0);
        check("mid_rst_busy", 32'(clear_busy), 32'd1);
        tick();
        reset = 1'b0;
        bus_read(ra(8'hF4), 32'h80, "stat_after_rst");
        fetch(3, 2, 32'h0, "pix_reinit");
        wait_idle(n);
        fetch(3, 2, 32'h0, "pix_recleared");
        bus_read(pa(10, 5), 32'h0, "rd_recleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
